// File: rtl/ccgrcg_bist_pkg.sv
// ccgrcg_bist_pkg
//   Shared definitions for the CCGRCG BIST controller:
//   - state_e          : controller FSM states
//   - DEF_* constants  : default widths and feedback masks for LFSR and MISR
//   - masked_parity()  : XOR-reduction of a value under a feedback mask
//   No ports (package).
package ccgrcg_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_IN_W  = 27;
  localparam int DEF_OUT_W = 21;
  localparam int DEF_CNT_W = 16;

  // x^27 + x^5 + x^2 + x + 1
  localparam logic [26:0] DEF_LFSR_TAPS = 27'h4000013;
  // x^21 + x^19 + 1
  localparam logic [20:0] DEF_MISR_TAPS = 21'h140000;

  // Operand width of masked_parity; callers zero-extend narrower registers.
  localparam int PAR_W = 32;

  function automatic logic masked_parity(input logic [PAR_W-1:0] value,
                                         input logic [PAR_W-1:0] mask);
    return ^(value & mask);
  endfunction

endpackage

// File: rtl/ccgrcg_lfsr.sv
// ccgrcg_lfsr
//   Seedable Fibonacci shift register. Shifts left; the new LSB is the parity
//   of the current state under TAPS. load has priority over en.
//   Ports:
//     clk       in   clock, rising edge
//     rst       in   asynchronous active-high reset (state = 1)
//     load      in   load load_val this cycle
//     load_val  in   W-bit value to load
//     en        in   advance one step this cycle
//     q         out  current register contents
module ccgrcg_lfsr
  import ccgrcg_bist_pkg::*;
#(
  parameter int           W    = DEF_IN_W,
  parameter logic [W-1:0] TAPS = DEF_LFSR_TAPS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] lfsr_q;
  logic [W-1:0] lfsr_d;
  logic         fb_s;

  always_comb begin
    fb_s   = masked_parity({{(PAR_W-W){1'b0}}, lfsr_q}, {{(PAR_W-W){1'b0}}, TAPS});
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = load_val;
    end else if (en) begin
      lfsr_d = {lfsr_q[W-2:0], fb_s};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= {{(W-1){1'b0}}, 1'b1};
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/ccgrcg_bist_ctrl.sv
// ccgrcg_bist_ctrl
//   BIST controller around a combinational CCGRCG netlist: issues LFSR vectors
//   on dut_x, compacts dut_f into a MISR one cycle later, and compares the
//   final signature against a golden value.
//   Ports:
//     clk, rst     clock (rising) and asynchronous active-high reset
//     start        1-cycle pulse, accepted in IDLE or DONE
//     abort        return to IDLE from any state, dominates start
//     seed         LFSR seed (0 is replaced by 1), sampled on accepted start
//     num_vecs     vectors to apply, sampled on accepted start
//     golden_sig   expected signature, sampled on accepted start
//     dut_x        registered vector to the netlist inputs
//     dut_f        netlist outputs, combinational from dut_x
//     busy         high in RUN and DRAIN
//     done         high in DONE
//     pass         in DONE: signature equals latched golden value
//     signature    current MISR contents
//     vec_cnt      vectors applied so far
module ccgrcg_bist_ctrl
  import ccgrcg_bist_pkg::*;
#(
  parameter int               IN_W      = DEF_IN_W,
  parameter int               OUT_W     = DEF_OUT_W,
  parameter int               CNT_W     = DEF_CNT_W,
  parameter logic [IN_W-1:0]  LFSR_TAPS = DEF_LFSR_TAPS,
  parameter logic [OUT_W-1:0] MISR_TAPS = DEF_MISR_TAPS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [IN_W-1:0]  seed,
  input  logic [CNT_W-1:0] num_vecs,
  input  logic [OUT_W-1:0] golden_sig,
  output logic [IN_W-1:0]  dut_x,
  input  logic [OUT_W-1:0] dut_f,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] signature,
  output logic [CNT_W-1:0] vec_cnt
);

  state_e           state_q, state_d;
  logic [IN_W-1:0]  dut_x_q, dut_x_d;
  logic [OUT_W-1:0] misr_q, misr_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [OUT_W-1:0] golden_q, golden_d;
  logic             cap_vld_q, cap_vld_d;

  logic             start_acc_s;
  logic             last_issue_s;
  logic             lfsr_en_s;
  logic [IN_W-1:0]  lfsr_seed_s;
  logic [IN_W-1:0]  lfsr_s;
  logic             misr_fb_s;
  logic             busy_s, done_s, pass_s;

  assign start_acc_s  = start && !abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  // num_q is never 0 while in RUN, so the subtraction cannot underflow here.
  assign last_issue_s = (vec_cnt_q == (num_q - {{(CNT_W-1){1'b0}}, 1'b1}));
  assign lfsr_en_s    = (state_q == ST_RUN) && !abort;
  assign lfsr_seed_s  = (seed == {IN_W{1'b0}}) ? {{(IN_W-1){1'b0}}, 1'b1} : seed;

  ccgrcg_lfsr #(
    .W    (IN_W),
    .TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (start_acc_s),
    .load_val (lfsr_seed_s),
    .en       (lfsr_en_s),
    .q        (lfsr_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d = (num_vecs == {CNT_W{1'b0}}) ? ST_DONE : ST_RUN;
          end else begin
            state_d = state_q;
          end
        end
        ST_RUN: begin
          if (last_issue_s) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DRAIN: state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM output decode.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_q)
      ST_RUN, ST_DRAIN: busy_s = 1'b1;
      ST_DONE:          done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
    pass_s = done_s && (misr_q == golden_q);
  end

  // Datapath next values: vector issue, response capture, run bookkeeping.
  always_comb begin
    misr_fb_s = masked_parity({{(PAR_W-OUT_W){1'b0}}, misr_q},
                              {{(PAR_W-OUT_W){1'b0}}, MISR_TAPS});
    dut_x_d   = dut_x_q;
    misr_d    = misr_q;
    vec_cnt_d = vec_cnt_q;
    num_d     = num_q;
    golden_d  = golden_q;
    cap_vld_d = 1'b0;
    if (abort) begin
      // misr and vec_cnt are left as they were for post-mortem inspection.
      cap_vld_d = 1'b0;
    end else begin
      // cap_vld_q marks that dut_x was updated on the previous edge, so dut_f
      // now reflects the vector issued one cycle ago.
      if (cap_vld_q) begin
        misr_d = {misr_q[OUT_W-2:0], misr_fb_s} ^ dut_f;
      end else begin
        misr_d = misr_q;
      end
      if (start_acc_s) begin
        misr_d    = {OUT_W{1'b0}};
        vec_cnt_d = {CNT_W{1'b0}};
        num_d     = num_vecs;
        golden_d  = golden_sig;
        cap_vld_d = 1'b0;
      end else if (state_q == ST_RUN) begin
        dut_x_d   = lfsr_s;
        vec_cnt_d = vec_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        cap_vld_d = 1'b1;
      end else begin
        cap_vld_d = 1'b0;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dut_x_q   <= {IN_W{1'b0}};
      misr_q    <= {OUT_W{1'b0}};
      vec_cnt_q <= {CNT_W{1'b0}};
      num_q     <= {CNT_W{1'b0}};
      golden_q  <= {OUT_W{1'b0}};
      cap_vld_q <= 1'b0;
    end else begin
      dut_x_q   <= dut_x_d;
      misr_q    <= misr_d;
      vec_cnt_q <= vec_cnt_d;
      num_q     <= num_d;
      golden_q  <= golden_d;
      cap_vld_q <= cap_vld_d;
    end
  end

  assign dut_x     = dut_x_q;
  assign busy      = busy_s;
  assign done      = done_s;
  assign pass      = pass_s;
  assign signature = misr_q;
  assign vec_cnt   = vec_cnt_q;

endmodule

// File: tb/tb_ccgrcg_bist_ctrl.sv
// tb_ccgrcg_bist_ctrl
//   Self-checking bench for ccgrcg_bist_ctrl. A stand-in netlist (f_mode=1,
//   with f(x=1)=0) or a constant-1 stub (f_mode=0) drives dut_f.
module tb_ccgrcg_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [26:0] seed;
  logic [15:0] num_vecs;
  logic [20:0] golden_sig;
  logic [26:0] dut_x;
  logic [20:0] dut_f;
  logic        busy, done, pass;
  logic [20:0] signature;
  logic [15:0] vec_cnt;

  logic        f_mode;
  int          checks = 0;
  int          errors = 0;

  logic [26:0] obs_x[$];
  logic [26:0] model_x[$];
  logic [20:0] model_sig;
  int          busy_cycles;
  bit          done_seen;

  typedef struct {
    string       name;
    logic [26:0] seed;
    logic [15:0] n;
    logic [20:0] golden;
    logic        fm;
    logic [20:0] exp_sig;
    logic        exp_pass;
    logic [26:0] exp_last_x;
  } vec_t;

  vec_t tbl[5];

  always #5 clk = ~clk;

  ccgrcg_bist_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .seed       (seed),
    .num_vecs   (num_vecs),
    .golden_sig (golden_sig),
    .dut_x      (dut_x),
    .dut_f      (dut_f),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .signature  (signature),
    .vec_cnt    (vec_cnt)
  );

  // Stand-in combinational netlist; bit 0 of x never reaches f, so f(1)=0.
  function automatic logic [20:0] net_f(input logic [26:0] x);
    return x[21:1] ^ x[26:6] ^ {x[10:1], x[26:16]};
  endfunction

  function automatic logic [20:0] f_of(input logic [26:0] x, input logic fm);
    return fm ? net_f(x) : 21'h1;
  endfunction

  always_comb dut_f = f_of(dut_x, f_mode);

  // Reference: polynomial steps computed from popcount parity.
  function automatic logic [26:0] lfsr_step(input logic [26:0] s);
    int ones;
    ones = $countones(s & 27'h4000013);
    return {s[25:0], ones[0]};
  endfunction

  function automatic logic [20:0] misr_step(input logic [20:0] m);
    int ones;
    ones = $countones(m & 21'h140000);
    return {m[19:0], ones[0]};
  endfunction

  task automatic model_run(input logic [26:0] s0, input int n, input logic fm);
    logic [26:0] s;
    logic [20:0] m;
    model_x.delete();
    s = (s0 == 27'd0) ? 27'd1 : s0;
    m = 21'd0;
    for (int i = 0; i < n; i++) begin
      model_x.push_back(s);
      m = misr_step(m) ^ f_of(s, fm);
      s = lfsr_step(s);
    end
    model_sig = m;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pulse start and follow the run until done, recording every issued vector.
  task automatic do_run(input logic [26:0] s, input logic [15:0] n,
                        input logic [20:0] g, input bit inj);
    @(negedge clk);
    seed = s; num_vecs = n; golden_sig = g; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    obs_x.delete();
    busy_cycles = 0;
    done_seen = 1'b0;
    for (int i = 0; i < int'(n) + 10; i++) begin
      if (done) begin
        done_seen = 1'b1;
        break;
      end
      if (busy) begin
        if (busy_cycles > 0) obs_x.push_back(dut_x);
        busy_cycles++;
      end
      // A start while busy must be ignored.
      if (inj && busy_cycles == 2) begin
        start = 1'b1; seed = s ^ 27'h5A5A5; num_vecs = 16'd3;
      end else begin
        start = 1'b0; seed = s; num_vecs = n;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_seq(input string name);
    check({name, "_len"}, 32'(obs_x.size()), 32'(model_x.size()));
    if (obs_x.size() == model_x.size()) begin
      for (int k = 0; k < obs_x.size(); k++)
        check($sformatf("%s_x%0d", name, k), 32'(obs_x[k]), 32'(model_x[k]));
    end
  endtask

  initial begin
    logic [26:0] t1_seq[4];
    logic [26:0] rs;
    logic [15:0] rn;
    logic [20:0] rg;
    logic        rp;

    t1_seq = '{27'h1, 27'h3, 27'h6, 27'hD};
    tbl[0] = '{"t1",   27'd1, 16'd4, 21'hF, 1'b0, 21'hF, 1'b1, 27'hD};
    tbl[1] = '{"t2_g0",27'd1, 16'd1, 21'h0, 1'b1, 21'h0, 1'b1, 27'h1};
    tbl[2] = '{"t2_g1",27'd1, 16'd1, 21'h1, 1'b1, 21'h0, 1'b0, 27'h1};
    tbl[3] = '{"t3",   27'd0, 16'd4, 21'h0, 1'b0, 21'hF, 1'b0, 27'hD};
    tbl[4] = '{"t5",   27'd1, 16'd3, 21'h7, 1'b0, 21'h7, 1'b1, 27'h6};

    rst = 1'b1; start = 1'b0; abort = 1'b0; seed = 27'd0;
    num_vecs = 16'd0; golden_sig = 21'd0; f_mode = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_sig", 32'(signature), 32'd0);
    check("rst_cnt", 32'(vec_cnt), 32'd0);
    check("rst_x", 32'(dut_x), 32'd0);

    for (int i = 0; i < 5; i++) begin
      f_mode = tbl[i].fm;
      do_run(tbl[i].seed, tbl[i].n, tbl[i].golden, 1'b0);
      check({tbl[i].name, "_done"}, 32'(done_seen), 32'd1);
      check({tbl[i].name, "_busy"}, 32'(busy_cycles), 32'(tbl[i].n) + 32'd1);
      check({tbl[i].name, "_cnt"}, 32'(vec_cnt), 32'(tbl[i].n));
      check({tbl[i].name, "_sig"}, 32'(signature), 32'(tbl[i].exp_sig));
      check({tbl[i].name, "_pass"}, 32'(pass), 32'(tbl[i].exp_pass));
      check({tbl[i].name, "_lastx"}, 32'(dut_x), 32'(tbl[i].exp_last_x));
      model_run(tbl[i].seed, int'(tbl[i].n), tbl[i].fm);
      check_seq(tbl[i].name);
      if (tbl[i].n == 16'd4 && obs_x.size() == 4) begin
        for (int k = 0; k < 4; k++)
          check($sformatf("%s_const_x%0d", tbl[i].name, k), 32'(obs_x[k]), 32'(t1_seq[k]));
      end
    end

    // T4: zero-length run completes next cycle, dut_x keeps the last vector (6).
    f_mode = 1'b1;
    do_run(27'd5, 16'd0, 21'd0, 1'b0);
    check("t4_done", 32'(done_seen), 32'd1);
    check("t4_busy", 32'(busy_cycles), 32'd0);
    check("t4_sig", 32'(signature), 32'd0);
    check("t4_pass", 32'(pass), 32'd1);
    check("t4_x", 32'(dut_x), 32'h6);
    check("t4_cnt", 32'(vec_cnt), 32'd0);

    // Randomized runs against the reference model.
    for (int r = 0; r < 25; r++) begin
      rs = 27'($urandom);
      if (r == 0) rs = 27'd0;
      rn = 16'($urandom_range(1, 40));
      model_run(rs, int'(rn), 1'b1);
      rg = ($urandom_range(0, 1) == 1) ? model_sig : 21'($urandom);
      rp = (rg == model_sig);
      do_run(rs, rn, rg, (r % 3) == 1);
      check($sformatf("rnd%0d_done", r), 32'(done_seen), 32'd1);
      check($sformatf("rnd%0d_cnt", r), 32'(vec_cnt), 32'(rn));
      check($sformatf("rnd%0d_sig", r), 32'(signature), 32'(model_sig));
      check($sformatf("rnd%0d_pass", r), 32'(pass), 32'(rp));
      check_seq($sformatf("rnd%0d", r));
    end

    // T6a: abort at vec_cnt=2 of 10.
    @(negedge clk);
    seed = 27'd5; num_vecs = 16'd10; golden_sig = 21'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (vec_cnt == 16'd2) break;
      @(negedge clk);
    end
    check("t6_reach", 32'(vec_cnt), 32'd2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_cnt_kept", 32'(vec_cnt), 32'd2);
    repeat (3) @(negedge clk);
    check("t6_no_done", 32'(done), 32'd0);
    check("t6_idle_cnt", 32'(vec_cnt), 32'd2);

    // T6b: asynchronous reset in the middle of a run.
    seed = 27'd5; num_vecs = 16'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_midrun_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6r_busy", 32'(busy), 32'd0);
    check("t6r_done", 32'(done), 32'd0);
    check("t6r_pass", 32'(pass), 32'd0);
    check("t6r_sig", 32'(signature), 32'd0);
    check("t6r_cnt", 32'(vec_cnt), 32'd0);
    check("t6r_x", 32'(dut_x), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6r_after_busy", 32'(busy), 32'd0);
    check("t6r_after_done", 32'(done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
